traffic_phase_ctrl: RTL and testbench



---
 rtl/traffic_phase_ctrl.sv | 167 ++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Demand-actuated round-robin intersection controller: green/amber/all-red per approach,
// empty approaches skipped, time advanced by tick. Optional flash mode under TPC_FLASH_EN.
module traffic_phase_ctrl #(
   parameter int NUM_DIR     = 4,
   parameter int TW          = 16,
   parameter int T_MIN_GREEN = 4,
   parameter int T_MAX_GREEN = 8,
   parameter int T_AMBER     = 3,
   parameter int T_ALL_RED   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic [NUM_DIR-1:0]         det,
`ifdef TPC_FLASH_EN
   input  logic                       flash_req,
`endif
   output logic [NUM_DIR-1:0]         red,
   output logic [NUM_DIR-1:0]         amber,
   output logic [NUM_DIR-1:0]         green,
   output logic [$clog2(NUM_DIR)-1:0] cur_dir,
   output logic [1:0]                 state,
   output logic [NUM_DIR-1:0]         req
);

   localparam int DW = $clog2(NUM_DIR);
   localparam logic [TW:0]   L_MIN  = (TW+1)'(T_MIN_GREEN);
   localparam logic [TW:0]   L_MAX  = (TW+1)'(T_MAX_GREEN);
   localparam logic [TW:0]   L_AMB  = (TW+1)'(T_AMBER);
   localparam logic [TW:0]   L_AR   = (TW+1)'(T_ALL_RED);
   localparam logic [TW-1:0] L_MAXN = TW'(T_MAX_GREEN);

   typedef enum logic [1:0] {
      S_GREEN   = 2'd0,
      S_AMBER   = 2'd1,
      S_ALL_RED = 2'd2,
      S_FLASH   = 2'd3
   } state_t;

   state_t               r_state;
   logic [DW-1:0]        r_cur;
   logic [NUM_DIR-1:0]   r_req;
   logic [TW-1:0]        r_ecnt;
   logic                 r_blink;

   logic                 w_flash;
   logic [TW:0]          w_e;
   logic [NUM_DIR-1:0]   w_cur_oh;
   logic [NUM_DIR-1:0]   w_own;
   logic                 w_comp;
   logic [DW-1:0]        w_next;
   logic                 w_found;
   logic                 w_ar_done;
   logic                 w_enter_green;
   logic [NUM_DIR-1:0]   w_clr;
   logic [NUM_DIR-1:0]   w_req_nxt;

`ifdef TPC_FLASH_EN
   assign w_flash = flash_req;
`else
   assign w_flash = 1'b0;
`endif

   assign w_e      = {1'b0, r_ecnt} + (TW+1)'(1);
   assign w_cur_oh = NUM_DIR'(1) << r_cur;
   assign w_comp   = |(r_req & ~w_cur_oh);

   // Circular search starting after the current owner; the owner itself is checked last.
   always_comb begin
      int v_idx;
      v_idx   = 0;
      w_next  = r_cur;
      w_found = 1'b0;
      for (int k = 1; k <= NUM_DIR; k++) begin
         v_idx = (int'(r_cur) + k) % NUM_DIR;
         if (!w_found && r_req[DW'(v_idx)]) begin
            w_next  = DW'(v_idx);
            w_found = 1'b1;
         end
      end
   end

   assign w_ar_done     = (r_state == S_ALL_RED) && tick && (w_e == L_AR);
   assign w_enter_green = w_ar_done && !w_flash;
   assign w_own         = (r_state == S_GREEN) ? w_cur_oh : '0;
   assign w_clr         = w_enter_green ? (NUM_DIR'(1) << w_next) : '0;
   assign w_req_nxt     = (r_req | (det & ~w_own)) & ~w_clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_ALL_RED;
         r_cur   <= '0;
         r_req   <= '0;
         r_ecnt  <= '0;
         r_blink <= 1'b1;
      end else begin
         r_req <= w_req_nxt;
         case (r_state)
            S_GREEN: if (tick) begin
               if (w_flash || ((w_e >= L_MIN) && w_comp &&
                               (!det[r_cur] || (w_e >= L_MAX)))) begin
                  r_state <= S_AMBER;
                  r_ecnt  <= '0;
               end else begin
                  r_ecnt  <= (w_e >= L_MAX) ? L_MAXN : w_e[TW-1:0];
               end
            end
            S_AMBER: if (tick) begin
               if (w_e == L_AMB) begin
                  r_state <= S_ALL_RED;
                  r_ecnt  <= '0;
               end else begin
                  r_ecnt  <= w_e[TW-1:0];
               end
            end
            S_ALL_RED: if (tick) begin
               if (w_e == L_AR) begin
                  r_ecnt <= '0;
                  if (w_flash) begin
                     r_state <= S_FLASH;
                     r_blink <= 1'b1;
                  end else begin
                     r_state <= S_GREEN;
                     r_cur   <= w_next;
                  end
               end else begin
                  r_ecnt <= w_e[TW-1:0];
               end
            end
            S_FLASH: if (tick) begin
               r_blink <= ~r_blink;
               if (!w_flash) begin
                  r_state <= S_ALL_RED;
                  r_ecnt  <= '0;
               end
            end
            default: r_state <= S_ALL_RED;
         endcase
      end
   end

   always_comb begin
      red   = '1;
      amber = '0;
      green = '0;
      case (r_state)
         S_GREEN: begin
            red   = ~w_cur_oh;
            green = w_cur_oh;
         end
         S_AMBER: begin
            red   = ~w_cur_oh;
            amber = w_cur_oh;
         end
         S_FLASH: begin
            red   = '0;
            amber = {NUM_DIR{r_blink}};
         end
         default: ;
      endcase
   end

   assign cur_dir = r_cur;
   assign state   = r_state;
   assign req     = r_req;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized scoreboard bench for traffic_phase_ctrl: a phase-level reference model
// predicts every post-edge output; a separate monitor pops and compares.
module tb_traffic_phase_ctrl;
   localparam int N    = 4;
   localparam int MIN  = 4;
   localparam int MAX  = 8;
   localparam int AMB  = 3;
   localparam int AR   = 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tick = 1'b0;
   logic [N-1:0] det = '0;
   logic         flash_req = 1'b0;
   logic [N-1:0] red, amber, green, req;
   logic [1:0]   cur_dir;
   logic [1:0]   state;

   traffic_phase_ctrl dut (
      .clk(clk), .rst(rst), .tick(tick), .det(det),
`ifdef TPC_FLASH_EN
      .flash_req(flash_req),
`endif
      .red(red), .amber(amber), .green(green),
      .cur_dir(cur_dir), .state(state), .req(req)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int n_cyc = 0;
   logic [19:0] exp_q[$];

   // Reference model: phase name, owner, pending-demand set, ticks spent in phase.
   int           m_ph = 2;
   int           m_dir = 0;
   logic [N-1:0] m_dem = '0;
   int           m_el = 0;
   logic         m_blink = 1'b1;

   task automatic model_step(input logic r, input logic [N-1:0] d, input logic t,
                             input logic f);
      logic [N-1:0] nd;
      int           cand[$];
      bit           comp;
      if (r) begin
         m_ph = 2; m_dir = 0; m_dem = '0; m_el = 0; m_blink = 1'b1;
         return;
      end
      nd = m_dem;
      for (int i = 0; i < N; i++)
         if (d[i] && !(m_ph == 0 && m_dir == i)) nd[i] = 1'b1;
      if (t) begin
         case (m_ph)
            0: begin
               comp = 0;
               for (int i = 0; i < N; i++) if (i != m_dir && m_dem[i]) comp = 1;
               m_el++;
               if (f || (m_el >= MIN && comp && (!d[m_dir] || m_el >= MAX))) begin
                  m_ph = 1; m_el = 0;
               end
            end
            1: begin
               m_el++;
               if (m_el == AMB) begin m_ph = 2; m_el = 0; end
            end
            2: begin
               m_el++;
               if (m_el == AR) begin
                  m_el = 0;
                  if (f) begin
                     m_ph = 3; m_blink = 1'b1;
                  end else begin
                     for (int k = 1; k <= N; k++)
                        if (m_dem[(m_dir + k) % N]) cand.push_back((m_dir + k) % N);
                     if (cand.size() > 0) m_dir = cand[0];
                     m_ph = 0;
                     nd[m_dir] = 1'b0;
                  end
               end
            end
            default: begin
               m_blink = !m_blink;
               if (!f) begin m_ph = 2; m_el = 0; end
            end
         endcase
      end
      m_dem = nd;
   endtask

   function automatic logic [19:0] exp_vec();
      logic [N-1:0] oh, r, a, g;
      oh = '0; oh[m_dir] = 1'b1;
      r = '1; a = '0; g = '0;
      case (m_ph)
         0: begin r = ~oh; g = oh; end
         1: begin r = ~oh; a = oh; end
         3: begin r = '0; a = {N{m_blink}}; end
         default: ;
      endcase
      return {2'(m_ph), 2'(m_dir), m_dem, r, a, g};
   endfunction

   task automatic cyc(input logic r, input logic [N-1:0] d, input logic t, input logic f);
      @(negedge clk);
      rst = r; det = d; tick = t; flash_req = f;
      model_step(r, d, t, f);
      exp_q.push_back(exp_vec());
   endtask

   // Monitor: outputs are valid every cycle; compare one expectation per edge.
   initial begin
      logic [19:0] e, a;
      forever begin
         @(posedge clk);
         #1;
         n_cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, cur_dir, req, red, amber, green};
            n_chk++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL cycle %0d {state,cur,req,red,amb,grn}: got %h/%h/%b/%b/%b/%b want %h/%h/%b/%b/%b/%b",
                        n_cyc, a[19:18], a[17:16], a[15:12], a[11:8], a[7:4], a[3:0],
                        e[19:18], e[17:16], e[15:12], e[11:8], e[7:4], e[3:0]);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] d;
      logic         f;
      bit           hit;
      cyc(1, '0, 1, 0);
      cyc(1, '0, 1, 0);
      // Idle rest on approach 0
      for (int i = 0; i < 100; i++) cyc(0, '0, 1, 0);
      // Single-cycle pulse on approach 2 skips approach 1
      cyc(0, 4'b0100, 1, 0);
      for (int i = 0; i < 20; i++) cyc(0, '0, 1, 0);
      // Competing demand with the owner held: max green
      cyc(0, 4'b1111, 1, 0);
      for (int i = 0; i < 60; i++) cyc(0, 4'b0001 << m_dir, 1, 0);
      // Wrap-around: demand behind the owner
      cyc(0, 4'b0110, 1, 0);
      for (int i = 0; i < 40; i++) cyc(0, '0, 1, 0);
      // Random traffic with sparse ticks
      f = 0;
      for (int i = 0; i < 2000; i++) begin
         d = '0;
         for (int j = 0; j < N; j++) d[j] = ($urandom % 12) == 0;
         if (($urandom % 8) == 0) d = '1;
`ifdef TPC_FLASH_EN
         if (($urandom % 150) == 0) f = !f;
`endif
         cyc(0, d, ($urandom % 4) != 0, f);
      end
      for (int i = 0; i < 10; i++) cyc(0, '0, 1, 0);
      // Drive toward amber, then reset asynchronously mid-phase
      hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
         if (m_ph == 1) hit = 1;
         else cyc(0, 4'b1111, 1, 0);
      end
      n_chk++;
      if (!hit) begin
         n_fail++;
         $display("FAIL amber_wait: got no amber within 300 cycles, want amber");
      end
      @(negedge clk);
      rst = 1'b1; tick = 1'b1;
      #1;
      n_chk++;
      if ({red, amber, green, state} !== {4'b1111, 4'b0000, 4'b0000, 2'd2}) begin
         n_fail++;
         $display("FAIL async_reset: got red=%b amber=%b green=%b state=%0d want 1111/0000/0000/2",
                  red, amber, green, state);
      end
      model_step(1, det, 1, 0);
      exp_q.push_back(exp_vec());
      for (int i = 0; i < 20; i++) cyc(0, 4'b0010, 1, 0);
`ifdef TPC_FLASH_EN
      for (int i = 0; i < 30; i++) cyc(0, 4'b0100, 1, 1);
      for (int i = 0; i < 20; i++) cyc(0, '0, 1, 0);
`endif
      @(posedge clk);
      #3;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
